// File: rtl/cla_shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one 8-bit
// carry look-ahead adder; one partial-product add per clock, 16-bit product.

module CLA (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [8:0] S
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       g_lo;
  logic       p_lo;

  assign g = A & B;
  assign p = A ^ B;

  // Two 4-bit lookahead groups; the upper group's carry-in comes from the
  // lower group's generate/propagate terms rather than rippling through it.
  assign g_lo = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p_lo = &p[3:0];

  assign c[0] = 1'b0;
  assign c[1] = g[0];
  assign c[2] = g[1] | (p[1] & g[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
  assign c[4] = g_lo | (p_lo & c[0]);
  assign c[5] = g[4] | (p[4] & c[4]);
  assign c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
  assign c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
  assign c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4])
              | (p[7] & p[6] & p[5] & p[4] & c[4]);

  assign S = {c[8], p ^ c[7:0]};

endmodule

module cla_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [3:0]       count;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] sum;
  logic             c;

  assign addend = q[0] ? m : '0;

  CLA adder (
    .A (acc),
    .B (addend),
    .S (s)
  );

  assign sum = s[WIDTH-1:0];
  assign c   = s[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == 4'd7) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The adder carry lands in acc's MSB through the 17-bit right shift, so no
  // partial-product bit is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        CALC: begin
          {acc, q} <= {c, sum, q[WIDTH-1:1]};
          count    <= count + 4'd1;
          if (count == 4'd7) product <= {c, sum, q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_shift_add_multiplier.sv
// Scoreboard bench: stimulus pushes hand-computed products, a negedge
// monitor pops and checks them (plus latency and pulse shape) on each done.

module tb_cla_shift_add_multiplier;

  typedef struct {
    logic [15:0] product;
    int          accept_edge;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  exp_t exp_q[$];
  int   cyc;
  int   total_checks;
  int   fail_count;
  int   busy_run;
  logic prev_done;

  cla_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total_checks++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Issues a one-cycle start with the DUT in IDLE and queues the expected result.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [15:0] expected, input string name);
    exp_t e;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    e.product     = expected;
    e.accept_edge = cyc + 1;
    e.name        = name;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total_checks++;
      fail_count++;
      $display("[TB] FAIL drain_timeout: %0d results still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: pulse shape, busy length and latency are checked at every done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        checkOutput("done_one_cycle", {15'd0, prev_done}, 16'h0000);
        checkOutput("busy_low_at_done", {15'd0, busy}, 16'h0000);
        checkOutput("busy_cycles", busy_run[15:0], 16'd8);
        if (exp_q.size() == 0) begin
          total_checks++;
          fail_count++;
          $display("[TB] FAIL unexpected_done: got product 0x%04h, expected no done", product);
        end else begin
          e = exp_q.pop_front();
          checkOutput({e.name, "_product"}, product, e.product);
          checkOutput({e.name, "_latency"}, 16'(cyc - e.accept_edge), 16'd8);
        end
      end
      if (!busy) busy_run = 0;
      prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    rst_n        = 1'b0;
    start        = 1'b0;
    a            = 8'h00;
    b            = 8'h00;
    total_checks = 0;
    fail_count   = 0;
    cyc          = 0;
    busy_run     = 0;
    prev_done    = 1'b0;

    #12;
    checkOutput("reset_busy", {15'd0, busy}, 16'h0000);
    checkOutput("reset_done", {15'd0, done}, 16'h0000);
    checkOutput("reset_product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd0,   8'd0,   16'h0000, "mul_0x0");
    waitDrain(20);
    applyStimulus(8'd1,   8'd1,   16'h0001, "mul_1x1");
    waitDrain(20);
    applyStimulus(8'd10,  8'd5,   16'h0032, "mul_10x5");
    waitDrain(20);
    applyStimulus(8'd255, 8'd255, 16'hFE01, "mul_255x255");
    waitDrain(20);
    applyStimulus(8'd170, 8'd85,  16'h3872, "mul_170x85");
    waitDrain(20);

    // A start pulse in the middle of CALC must neither restart nor recapture.
    applyStimulus(8'd12, 8'd12, 16'h0090, "mul_12x12");
    @(negedge clk);
    a     = 8'd3;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    waitDrain(20);
    repeat (12) @(negedge clk);
    checkOutput("ignored_start_product", product, 16'h0090);

    // Reset in the middle of CALC; nothing is queued so any done is flagged.
    @(negedge clk);
    a     = 8'd200;
    b     = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("calc_busy", {15'd0, busy}, 16'h0001);
    checkOutput("product_hold_in_calc", product, 16'h0090);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {15'd0, busy}, 16'h0000);
    checkOutput("async_reset_done", {15'd0, done}, 16'h0000);
    checkOutput("async_reset_product", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("post_reset_product", product, 16'h0000);

    applyStimulus(8'd7, 8'd9, 16'h003F, "mul_7x9");
    waitDrain(20);

    // Held start: back-to-back multiplies, each accepted 10 edges after the last.
    @(negedge clk);
    a     = 8'd2;
    b     = 8'd3;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.product     = 16'h0006;
      e.accept_edge = cyc + 1 + 10 * k;
      e.name        = $sformatf("held_start_%0d", k);
      exp_q.push_back(e);
    end
    waitDrain(45);
    start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("held_start_final_product", product, 16'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
